// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and IM.
// The fetch unit is the master: it holds IM_req/IM_address steady until IM_ready.
interface fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] IM_address;
  logic              IM_req;
  logic              IM_ready;
  logic [31:0]       IM_data;

  modport master (output IM_address, output IM_req, input IM_ready, input IM_data);
  modport slave  (input IM_address, input IM_req, output IM_ready, output IM_data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, fetches over the IM bus into ir,
// holds ir for the controller, and handles branch redirects with one flush bubble.
module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  fetch_unit_if.master      im,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_busy
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_HOLD, F_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
      pend_q     <= 1'b0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ir_pc_d    = ir_pc_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    unique case (state_q)
      F_IDLE, F_FLUSH: begin
        req_d   = 1'b1;
        addr_d  = fetch_pc_q;
        state_d = F_REQ;
      end
      F_REQ: begin
        if (im.IM_ready) begin
          req_d = 1'b0;
          if (!pend_q && !branch_valid) begin
            ir_d       = im.IM_data;
            ir_pc_d    = addr_q;
            ir_valid_d = 1'b1;
            fetch_pc_d = ADDR_W'(addr_q + ADDR_W'(PC_STEP));
            state_d    = F_HOLD;
          end else begin
            // A redirect arriving with the response is newer than any latched one.
            fetch_pc_d = branch_valid ? branch_target : tgt_q;
            pend_d     = 1'b0;
            state_d    = F_FLUSH;
          end
        end else if (branch_valid) begin
          tgt_d  = branch_target;
          pend_d = 1'b1;
        end
      end
      F_HOLD: begin
        if (enable_pc) begin
          ir_valid_d = 1'b0;
          req_d      = 1'b1;
          addr_d     = branch_valid ? branch_target : fetch_pc_q;
          state_d    = F_REQ;
        end else if (branch_valid) begin
          fetch_pc_d = branch_target;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign im.IM_req     = req_q;
  assign im.IM_address = addr_q;
  assign ir            = ir_q;
  assign ir_valid      = ir_valid_q;
  assign ir_pc         = ir_pc_q;
  assign fetch_busy    = (state_q != F_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance A, plus instance B with RESET_PC=3FC for wrap.
module tb_fetch_unit;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          rst_a, rst_b;
  logic          en_a, bv_a, en_b, bv_b;
  logic [AW-1:0] bt_a, bt_b;
  logic [31:0]   ir_a, ir_b;
  logic          irv_a, irv_b, busy_a, busy_b;
  logic [AW-1:0] irpc_a, irpc_b;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit_if #(.ADDR_W(AW)) ifa ();
  fetch_unit_if #(.ADDR_W(AW)) ifb ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(10'h000), .PC_STEP(4)) dut_a (
    .clock(clock), .reset(rst_a), .enable_pc(en_a), .branch_valid(bv_a),
    .branch_target(bt_a), .im(ifa), .ir(ir_a), .ir_valid(irv_a),
    .ir_pc(irpc_a), .fetch_busy(busy_a));

  fetch_unit #(.ADDR_W(AW), .RESET_PC(10'h3FC), .PC_STEP(4)) dut_b (
    .clock(clock), .reset(rst_b), .enable_pc(en_b), .branch_valid(bv_b),
    .branch_target(bt_b), .im(ifb), .ir(ir_b), .ir_valid(irv_b),
    .ir_pc(irpc_b), .fetch_busy(busy_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    en_a = 0; bv_a = 0; bt_a = '0; en_b = 0; bv_b = 0; bt_b = '0;
    ifa.IM_ready = 1'b0; ifa.IM_data = '0;
    ifb.IM_ready = 1'b1; ifb.IM_data = 32'hF000_0000;
    #3;
    chk("rst_req",   {31'd0, ifa.IM_req}, 32'd0);
    chk("rst_ir",    ir_a, 32'd0);
    chk("rst_irv",   {31'd0, irv_a}, 32'd0);
    chk("rst_irpc",  {22'd0, irpc_a}, 32'd0);
    chk("rst_busy",  {31'd0, busy_a}, 32'd1);
    tick(); tick();

    // zero-wait first fetch
    rst_a = 1'b1;
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'hA000_0001;
    tick();
    chk("c1_req",    {31'd0, ifa.IM_req}, 32'd1);
    chk("c1_addr",   {22'd0, ifa.IM_address}, 32'h000);
    chk("c1_irv",    {31'd0, irv_a}, 32'd0);
    tick();
    chk("c2_ir",     ir_a, 32'hA000_0001);
    chk("c2_irpc",   {22'd0, irpc_a}, 32'h000);
    chk("c2_irv",    {31'd0, irv_a}, 32'd1);
    chk("c2_busy",   {31'd0, busy_a}, 32'd0);
    chk("c2_req",    {31'd0, ifa.IM_req}, 32'd0);
    ifa.IM_ready = 1'b0;

    // sequential fetch with 3 wait cycles
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w%0d_req", i),  {31'd0, ifa.IM_req}, 32'd1);
      chk($sformatf("w%0d_addr", i), {22'd0, ifa.IM_address}, 32'h004);
      chk($sformatf("w%0d_irv", i),  {31'd0, irv_a}, 32'd0);
      if (i < 2) tick();
    end
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'hB000_0002;
    tick();
    chk("seq_ir",    ir_a, 32'hB000_0002);
    chk("seq_irpc",  {22'd0, irpc_a}, 32'h004);
    chk("seq_irv",   {31'd0, irv_a}, 32'd1);
    ifa.IM_ready = 1'b0;

    // redirect during outstanding request at 8
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    chk("br_addr8",  {22'd0, ifa.IM_address}, 32'h008);
    bv_a = 1'b1; bt_a = 10'h040;
    tick();
    bv_a = 1'b0; bt_a = '0;
    chk("br_held",   {31'd0, ifa.IM_req}, 32'd1);
    chk("br_heldad", {22'd0, ifa.IM_address}, 32'h008);
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'hDEAD_BEEF;
    tick();
    chk("fl_req",    {31'd0, ifa.IM_req}, 32'd0);
    chk("fl_ir",     ir_a, 32'hB000_0002);
    chk("fl_irv",    {31'd0, irv_a}, 32'd0);
    chk("fl_busy",   {31'd0, busy_a}, 32'd1);
    ifa.IM_data = 32'hC000_0003;
    tick();
    chk("rr_req",    {31'd0, ifa.IM_req}, 32'd1);
    chk("rr_addr",   {22'd0, ifa.IM_address}, 32'h040);
    tick();
    chk("rr_ir",     ir_a, 32'hC000_0003);
    chk("rr_irpc",   {22'd0, irpc_a}, 32'h040);
    chk("rr_irv",    {31'd0, irv_a}, 32'd1);
    ifa.IM_ready = 1'b0;

    // branch together with enable_pc in HOLD
    en_a = 1'b1; bv_a = 1'b1; bt_a = 10'h100;
    tick();
    en_a = 1'b0; bv_a = 1'b0; bt_a = '0;
    chk("be_addr",   {22'd0, ifa.IM_address}, 32'h100);
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'hD000_0004;
    tick();
    chk("be_irpc",   {22'd0, irpc_a}, 32'h100);
    ifa.IM_ready = 1'b0;
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    chk("be_next",   {22'd0, ifa.IM_address}, 32'h104);
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'h1234_5678;
    tick();
    chk("n104_irpc", {22'd0, irpc_a}, 32'h104);
    ifa.IM_ready = 1'b0;

    // branch alone in HOLD, then enable_pc, then enable_pc ignored in REQ
    bv_a = 1'b1; bt_a = 10'h200;
    tick();
    bv_a = 1'b0; bt_a = '0;
    chk("bh_req",    {31'd0, ifa.IM_req}, 32'd0);
    chk("bh_irv",    {31'd0, irv_a}, 32'd1);
    chk("bh_ir",     ir_a, 32'h1234_5678);
    en_a = 1'b1;
    tick();
    chk("bh_addr",   {22'd0, ifa.IM_address}, 32'h200);
    tick();
    en_a = 1'b0;
    chk("ign_addr",  {22'd0, ifa.IM_address}, 32'h200);
    chk("ign_req",   {31'd0, ifa.IM_req}, 32'd1);

    // async reset mid-request
    #2;
    rst_a = 1'b0;
    #1;
    chk("ar_req",    {31'd0, ifa.IM_req}, 32'd0);
    chk("ar_irv",    {31'd0, irv_a}, 32'd0);
    chk("ar_ir",     ir_a, 32'd0);
    #1;
    rst_a = 1'b1;
    ifa.IM_ready = 1'b1; ifa.IM_data = 32'hE000_0005;
    tick();
    chk("ar_restart", {22'd0, ifa.IM_address}, 32'h000);
    chk("ar_req1",    {31'd0, ifa.IM_req}, 32'd1);
    tick();
    chk("ar_ir2",    ir_a, 32'hE000_0005);
    chk("ar_irpc2",  {22'd0, irpc_a}, 32'h000);

    // RESET_PC=3FC wrap on instance B
    rst_b = 1'b1;
    tick();
    chk("wr_addr0",  {22'd0, ifb.IM_address}, 32'h3FC);
    tick();
    chk("wr_irpc",   {22'd0, irpc_b}, 32'h3FC);
    chk("wr_ir",     ir_b, 32'hF000_0000);
    en_b = 1'b1;
    tick();
    en_b = 1'b0;
    chk("wr_wrap",   {22'd0, ifb.IM_address}, 32'h000);
    chk("wr_req",    {31'd0, ifb.IM_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the controller/register-fetch path.
- Owns the fetch PC and issues requests to instruction memory over a req/ready handshake.
- Captures the returned word into the instruction register `ir` and holds it stable for the controller's multi-cycle sequence.
- Advances on the controller's `enable_pc` pulse; takes branch redirects, discarding any in-flight fetch.

Parameters:
- ADDR_W, 10: width of PC and IM address.
- RESET_PC, 0: fetch address loaded on reset.
- PC_STEP, 4: sequential PC increment, in address units.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_pc  in  1  controller pulse: current `ir` consumed, fetch the next instruction.
- branch_valid  in  1  redirect request, single-cycle pulse.
- branch_target  in  ADDR_W  redirect address, valid with `branch_valid`.
- IM_address  out  ADDR_W  instruction memory address.
- IM_req  out  1  fetch request, registered.
- IM_ready  in  1  IM data valid; completes the request.
- IM_data  in  32  instruction word from IM.
- ir  out  32  instruction register feeding the controller.
- ir_valid  out  1  `ir` holds a valid instruction.
- ir_pc  out  ADDR_W  address of the instruction in `ir`.
- fetch_busy  out  1  high whenever state != F_HOLD.

Behaviour:
- Reset (reset=0, async) drives:
  - state=F_IDLE, fetch_pc=RESET_PC
  - ir=0, ir_valid=0, ir_pc=0
  - IM_req=0, redirect_pend=0
  - fetch_busy=1
- States: F_IDLE, F_REQ, F_HOLD, F_FLUSH.
- F_IDLE: next cycle -> F_REQ, with IM_req<=1 and IM_address<=fetch_pc. Entered only from reset.
- F_REQ: IM_req and IM_address are held constant until IM_ready=1. On IM_ready:
  - redirect_pend=0 and branch_valid=0:
    - ir<=IM_data, ir_pc<=IM_address, ir_valid<=1
    - fetch_pc<=IM_address+PC_STEP
    - IM_req<=0, -> F_HOLD
  - otherwise: IM_data is discarded; fetch_pc<=target (pending or current); IM_req<=0; redirect_pend<=0; -> F_FLUSH.
- branch_valid in F_REQ without IM_ready: latch branch_target, set redirect_pend=1, stay in F_REQ. The outstanding request is never withdrawn. A later branch_valid overwrites the latched target.
- F_FLUSH: one bubble cycle with IM_req=0; then -> F_REQ with IM_address=fetch_pc.
- F_HOLD: `ir`, `ir_pc`, ir_valid=1 stay stable.
  - branch_valid alone: fetch_pc<=branch_target; stay in F_HOLD.
  - enable_pc: ir_valid<=0; IM_req<=1; IM_address<=(branch_valid ? branch_target : fetch_pc); -> F_REQ. `ir` keeps its old value until overwritten.
- enable_pc outside F_HOLD: ignored, no queuing.
- Request latency: from enable_pc in F_HOLD, IM_req rises on the next edge. Zero-wait IM gives ir_valid high 2 cycles after the enable_pc edge.
- Arithmetic: fetch_pc+PC_STEP is modulo 2^ADDR_W, so it wraps to 0 silently.
- Reset mid-request: IM_req drops immediately (async) and the in-flight response is ignored. IM must tolerate abandoned requests.
- branch_target is not alignment-checked; it is used verbatim.

Test Plan:
- Reset then zero-wait IM returning 32'hA000_0001:
  - IM_req high at cycle 1 with IM_address=0.
  - ir=32'hA000_0001, ir_pc=0, ir_valid=1 at cycle 2; fetch_busy=0.
- From F_HOLD, pulse enable_pc; IM_ready delayed 3 cycles:
  - IM_req held with IM_address=4 for all 3 cycles.
  - ir_valid=0 until capture, then ir_pc=4.
- In F_HOLD, branch_valid with target 10'h100 and enable_pc in the same cycle: next IM_address=10'h100. After capture, ir_pc=10'h100 and fetch_pc=10'h104.
- branch_valid (target 10'h040) during an outstanding F_REQ at address 8:
  - the IM_data returned for 8 is discarded and ir stays at its prior value;
  - one IM_req=0 bubble cycle;
  - re-request at 10'h040, captured with ir_pc=10'h040.
- RESET_PC=10'h3FC: the first fetch is at 10'h3FC and the next sequential fetch is at 10'h000 (wrap).
- Assert reset while IM_req=1:
  - IM_req, ir_valid and ir go to 0 without a clock edge.
  - After release, fetch restarts at RESET_PC.
